// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sweeps a RAM address range and streams the words out with valid/ready backpressure.
// Define RAM_RDR_WRAP_EN to let the address range wrap past the top of the RAM instead of rejecting it.
module ram_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_data,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t state, next_state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH:0]   rem, len_r, dcnt;
   logic [1:0]            infl;
   logic [DATA_WIDTH-1:0] fifo [4];
   logic [1:0]            wr_ptr, rd_ptr;
   logic [2:0]            occ;
   logic reject, accept, room, issue, pop, is_last, done_d, err_d;
`ifdef RAM_RDR_WRAP_EN
   assign reject = 1'b0;
`else
   localparam logic [ADDR_WIDTH+1:0] SPAN = {2'b01, {ADDR_WIDTH{1'b0}}};
   logic [ADDR_WIDTH+1:0] end_sum;
   assign end_sum = {2'b00, start_addr} + {1'b0, len};
   assign reject  = end_sum > SPAN;
`endif
   assign ram_we    = 1'b0;
   assign ram_data  = '0;
   assign busy      = state != IDLE;
   assign out_valid = occ != 3'd0;
   assign out_data  = out_valid ? fifo[rd_ptr] : '0;
   assign is_last   = dcnt == len_r - 1'b1;
   assign out_last  = out_valid & is_last;
   assign pop       = out_valid & out_ready;
   assign accept    = (state == IDLE) & start & (len != '0) & ~reject;
   // Credit check: buffered plus in-flight words, net of this cycle's pop, must leave a free slot.
   assign room      = {1'b0, occ} + {3'b0, infl[0]} + {3'b0, infl[1]} <= 4'd3 + {3'b0, pop};
   always_comb begin
      next_state = state;
      issue      = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      case (state)
         IDLE: begin
            issue  = accept;
            err_d  = start & reject;
            done_d = start & (len == '0);
            if (accept) next_state = (len == 1) ? DRAIN : READ;
         end
         READ: begin
            issue = room;
            if (room && rem == 1) next_state = DRAIN;
         end
         DRAIN: begin
            done_d = pop & is_last;
            if (pop && is_last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next_state;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr <= '0;
         ptr      <= '0;
         rem      <= '0;
         len_r    <= '0;
         dcnt     <= '0;
         infl     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= done_d;
         err  <= err_d;
         infl <= {infl[0], issue};
         if (accept) begin
            ram_addr <= start_addr;
            ptr      <= start_addr + 1'b1;
            rem      <= len - 1'b1;
            len_r    <= len;
            dcnt     <= '0;
         end else if (issue) begin
            ram_addr <= ptr;
            ptr      <= ptr + 1'b1;
            rem      <= rem - 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            dcnt   <= dcnt + 1'b1;
         end
         if (infl[1]) wr_ptr <= wr_ptr + 1'b1;
         occ <= occ + {2'b0, infl[1]} - {2'b0, pop};
      end
   end
   always_ff @(posedge clk)
      if (infl[1]) fifo[wr_ptr] <= ram_q;
endmodule
